ssd_view_sched: RTL and testbench

Scheduler that shares the 8-digit multiplexed seven-segment display between four 32-bit debug sources, such as PC, instruction, ALU result and a selected register. It debounces a push-button to step through sources manually and supports a timed auto-rotate mode. It snapshots the selected source into a stable register so digits never tear mid-scan, and drives the value/dpValue inputs of the display driver. Its decimal points show which source is active and whether the view is frozen.

---
 rtl/ssd_view_sched.sv | 169 ++++++++++++++++
 tb/tb_ssd_view_sched.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_view_sched.sv
// Shares the 8-digit seven-segment display between four 32-bit debug sources.
// Handles a debounced step button, timed auto-rotation and a tear-free snapshot of the selected source.
module ssd_view_sched #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned ROTATE_CYCLES   = 200000000,
    parameter int unsigned FRAME_CYCLES    = 800000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] src0,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [31:0] src3,
    input  logic        btn_next,
    input  logic        auto_en,
    input  logic        freeze,
    output logic [31:0] value,
    output logic [7:0]  dpValue,
    output logic [1:0]  sel
);

    localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned ROT_W = (ROTATE_CYCLES > 1) ? $clog2(ROTATE_CYCLES) : 1;
    localparam int unsigned FRM_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROTATE_CYCLES - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_CYCLES - 1);

    typedef enum logic [0:0] {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic               btn_m;
    logic               btn_s;
    logic               btn_db;
    logic               btn_db_q;
    logic [DEB_W-1:0]   deb_cnt;
    logic               next_pulse;

    logic [ROT_W-1:0]   rot_q;
    logic [ROT_W-1:0]   rot_d;
    logic [1:0]         sel_d;
    logic [1:0]         sel_q;

    logic [FRM_W-1:0]   frm_cnt;
    logic               frame_tick;
    logic               load_pend;
    logic               load;
    logic [31:0]        src_mux;

    // Two-flop synchronizer followed by a counter-based debouncer on the button level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_m    <= 1'b0;
            btn_s    <= 1'b0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            deb_cnt  <= '0;
        end else begin
            btn_m    <= btn_next;
            btn_s    <= btn_m;
            btn_db_q <= btn_db;
            if (btn_s == btn_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                btn_db  <= btn_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    // Only the press edge steps the view; release is ignored.
    assign next_pulse = btn_db & ~btn_db_q;

    // Mode state, dwell counter and selected source index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MANUAL;
            rot_q   <= '0;
            sel     <= 2'd0;
        end else begin
            state_q <= state_d;
            rot_q   <= rot_d;
            sel     <= sel_d;
        end
    end

    // A press and a dwell expiry in the same cycle collapse into one step.
    always_comb begin
        state_d = state_q;
        rot_d   = rot_q;
        sel_d   = sel;
        case (state_q)
            MANUAL: begin
                rot_d = '0;
                if (next_pulse) begin
                    sel_d = sel + 2'd1;
                end
                if (auto_en) begin
                    state_d = AUTO;
                end
            end
            AUTO: begin
                if (!auto_en) begin
                    state_d = MANUAL;
                    rot_d   = '0;
                    if (next_pulse) begin
                        sel_d = sel + 2'd1;
                    end
                end else if (next_pulse || (rot_q == ROT_LAST)) begin
                    sel_d = sel + 2'd1;
                    rot_d = '0;
                end else begin
                    rot_d = rot_q + ROT_W'(1);
                end
            end
            default: begin
                state_d = MANUAL;
                rot_d   = '0;
            end
        endcase
    end

    always_comb begin
        src_mux = src0;
        case (sel)
            2'd0: src_mux = src0;
            2'd1: src_mux = src1;
            2'd2: src_mux = src2;
            2'd3: src_mux = src3;
            default: src_mux = src0;
        endcase
    end

    assign frame_tick = (frm_cnt == FRM_LAST);
    assign load       = (frame_tick | load_pend) & ~freeze;

    // Snapshot register: refreshed once per scan frame or promptly after a source change, unless frozen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frm_cnt   <= '0;
            sel_q     <= 2'd0;
            load_pend <= 1'b0;
            value     <= 32'd0;
            dpValue   <= 8'h01;
        end else begin
            frm_cnt <= frame_tick ? '0 : frm_cnt + FRM_W'(1);
            sel_q   <= sel;
            if (load) begin
                value <= src_mux;
            end
            // A fresh selection change outranks the clear so it is never lost.
            if (sel != sel_q) begin
                load_pend <= 1'b1;
            end else if (load) begin
                load_pend <= 1'b0;
            end
            dpValue <= (8'h01 << sel) | {freeze, 7'b000_0000};
        end
    end

endmodule

// File: tb/tb_ssd_view_sched.sv
// Self-checking bench for ssd_view_sched: sel-advance scoreboard plus direct value/dpValue checks.
module tb_ssd_view_sched;

    localparam int unsigned DEB = 4;
    localparam int unsigned ROT = 10;
    localparam int unsigned FRM = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] src0, src1, src2, src3;
    logic        btn_next, auto_en, freeze;
    logic [31:0] value;
    logic [7:0]  dpValue;
    logic [1:0]  sel;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frame0 = 0;

    typedef struct packed {
        logic [31:0] c;
        logic [1:0]  s;
    } adv_t;

    adv_t       adv_q[$];
    adv_t       mon_e;
    logic [1:0] sel_prev = 2'd0;
    bit         mon_en = 1'b0;

    ssd_view_sched #(
        .DEBOUNCE_CYCLES(DEB),
        .ROTATE_CYCLES  (ROT),
        .FRAME_CYCLES   (FRM)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .src0    (src0),
        .src1    (src1),
        .src2    (src2),
        .src3    (src3),
        .btn_next(btn_next),
        .auto_en (auto_en),
        .freeze  (freeze),
        .value   (value),
        .dpValue (dpValue),
        .sel     (sel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_adv(input int c, input logic [1:0] s);
        adv_t e;
        e.c = 32'(c);
        e.s = s;
        adv_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clean press: advance expected 7 edges after the press is driven.
    task automatic press(input logic [1:0] nsel);
        push_adv(cyc + 7, nsel);
        btn_next = 1'b1;
        step(8);
        btn_next = 1'b0;
        step(8);
    endtask

    // Every sel change must match the next scheduled advance, in cycle and value.
    always @(posedge clk) begin
        #1;
        if (mon_en && (sel != sel_prev)) begin
            if (adv_q.size() != 0) begin
                mon_e = adv_q.pop_front();
            end else begin
                mon_e.c = 32'hFFFF_FFFF;
                mon_e.s = ~sel;
            end
            check("adv_cycle", 32'(cyc), mon_e.c);
            check("adv_sel", 32'(sel), 32'(mon_e.s));
        end
        sel_prev = sel;
    end

    initial begin
        int n0;
        int p0;
        int r0;
        logic [31:0] drive;
        logic [31:0] exp_v;

        rst_n    = 1'b0;
        src0     = 32'h1111_1111;
        src1     = 32'h2222_2222;
        src2     = 32'h3333_3333;
        src3     = 32'h4444_4444;
        btn_next = 1'b0;
        auto_en  = 1'b0;
        freeze   = 1'b0;

        // Reset with inputs toggling.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            btn_next = ~btn_next;
            auto_en  = ~auto_en;
            freeze   = ~freeze;
        end
        check("rst_value", value, 32'd0);
        check("rst_dp", 32'(dpValue), 32'h01);
        check("rst_sel", 32'(sel), 32'd0);
        btn_next = 1'b0;
        auto_en  = 1'b0;
        freeze   = 1'b0;
        rst_n    = 1'b1;
        frame0   = cyc;
        mon_en   = 1'b1;
        step(7);
        check("pre_frame_value", value, 32'd0);
        step(1);
        check("first_frame_value", value, 32'h1111_1111);

        // Short glitches must be rejected.
        btn_next = 1'b1;
        step(1);
        btn_next = 1'b0;
        step(8);
        btn_next = 1'b1;
        step(3);
        btn_next = 1'b0;
        step(8);
        check("glitch_sel", 32'(sel), 32'd0);

        // Long hold: exactly one advance at a known edge.
        p0 = cyc;
        push_adv(p0 + 7, 2'd1);
        btn_next = 1'b1;
        step(6);
        check("deb_early_sel", 32'(sel), 32'd0);
        step(1);
        check("deb_sel", 32'(sel), 32'd1);
        step(1);
        check("deb_dp", 32'(dpValue), 32'h02);
        step(1);
        check("deb_value", value, 32'h2222_2222);
        step(1);
        btn_next = 1'b0;
        step(10);

        press(2'd2);
        press(2'd3);
        press(2'd0);
        press(2'd1);
        check("wrap_sel", 32'(sel), 32'd1);

        // Auto rotation with a mid-dwell press and a press on the terminal count.
        n0 = cyc;
        push_adv(n0 + 11, 2'd2);
        push_adv(n0 + 21, 2'd3);
        push_adv(n0 + 31, 2'd0);
        push_adv(n0 + 41, 2'd1);
        push_adv(n0 + 47, 2'd2);
        push_adv(n0 + 57, 2'd3);
        push_adv(n0 + 67, 2'd0);
        push_adv(n0 + 77, 2'd1);
        for (int t = 0; t < 100; t++) begin
            btn_next = ((t >= 40) && (t < 48)) || ((t >= 60) && (t < 68));
            auto_en  = (t < 80);
            step(1);
        end
        check("auto_end_sel", 32'(sel), 32'd1);
        check("auto_end_value", value, 32'h2222_2222);

        // Freeze holds the snapshot; release loads the pending change next cycle.
        freeze = 1'b1;
        step(1);
        check("frz_dp1", 32'(dpValue), 32'h82);
        src2 = 32'hABCD_0002;
        press(2'd2);
        check("frz_value", value, 32'h2222_2222);
        check("frz_dp2", 32'(dpValue), 32'h84);
        step(8);
        check("frz_value_late", value, 32'h2222_2222);
        freeze = 1'b0;
        check("unfrz_same_cycle", value, 32'h2222_2222);
        step(1);
        check("unfrz_value", value, 32'hABCD_0002);
        check("unfrz_dp", 32'(dpValue), 32'h04);

        // Periodic refresh: source changes every cycle, snapshot follows only at frame ticks.
        exp_v = 32'hABCD_0002;
        for (int i = 0; i < 24; i++) begin
            drive = 32'h5A00_0000 | 32'(cyc);
            src2  = drive;
            step(1);
            if (((cyc - frame0) % FRM) == 0) begin
                exp_v = drive;
            end
            check("refresh_value", value, exp_v);
        end

        // Reset mid-debounce, in AUTO, frozen.
        p0 = cyc;
        push_adv(p0 + 5, 2'd0);
        btn_next = 1'b1;
        auto_en  = 1'b1;
        freeze   = 1'b1;
        step(4);
        rst_n    = 1'b0;
        btn_next = 1'b0;
        auto_en  = 1'b0;
        freeze   = 1'b0;
        step(3);
        check("rst2_sel", 32'(sel), 32'd0);
        check("rst2_value", value, 32'd0);
        check("rst2_dp", 32'(dpValue), 32'h01);
        rst_n   = 1'b1;
        auto_en = 1'b1;
        r0      = cyc;
        push_adv(r0 + 11, 2'd1);
        step(10);
        check("rst2_no_early_adv", 32'(sel), 32'd0);
        check("rst2_frame_value", value, 32'h1111_1111);
        step(1);
        check("rst2_auto_sel", 32'(sel), 32'd1);
        step(2);
        check("rst2_auto_value", value, 32'h2222_2222);
        auto_en = 1'b0;
        step(3);
        check("adv_pending", 32'(adv_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
